// File: rtl/prefetch_buffer_pkg.sv
// Shared types and constants for the instruction prefetch front end.
package prefetch_buffer_pkg;

  localparam logic [31:0] EXC_INSTR_MISALIGNED   = 32'd0;
  localparam logic [31:0] EXC_INSTR_ACCESS_FAULT = 32'd1;
  localparam logic [1:0]  AXI_RESP_OKAY          = 2'b00;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] ir;
    logic        exc_pend;
    logic [31:0] exc_cause;
  } fetch_entry_t;

endpackage

// File: rtl/prefetch_buffer_fifo_sync.sv
// Synchronous FIFO with flush and a registered head output (zero when empty).
module fifo_sync #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       flush,
  input  logic                       push,
  input  logic [WIDTH-1:0]           push_data,
  input  logic                       pop,
  output logic [WIDTH-1:0]           head,
  output logic                       not_empty,
  output logic [$clog2(DEPTH+1)-1:0] count
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = $clog2(DEPTH+1);
  localparam logic [CW-1:0] FULL = CW'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr, rd_ptr, rd_next;
  logic             push_en, pop_en;

  assign not_empty = (count != '0);
  assign pop_en    = pop && not_empty;
  assign push_en   = push && ((count != FULL) || pop_en);
  assign rd_next   = rd_ptr + 1'b1;

  always_ff @(posedge clk) begin
    if (push_en) mem[wr_ptr] <= push_data;
  end

  always_ff @(posedge clk) begin
    if (reset || flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      head   <= '0;
    end else begin
      if (push_en) wr_ptr <= wr_ptr + 1'b1;
      if (pop_en)  rd_ptr <= rd_next;
      count <= count + CW'(push_en) - CW'(pop_en);
      // Head register tracks mem[rd_ptr]; a push into an emptying FIFO bypasses memory.
      if (pop_en) begin
        if (count > CW'(1))  head <= mem[rd_next];
        else if (push_en)    head <= push_data;
        else                 head <= '0;
      end else if (push_en && count == '0) begin
        head <= push_data;
      end
    end
  end

endmodule

// File: rtl/prefetch_buffer.sv
// Instruction fetch front end: up to DEPTH AXI4-Lite reads in flight, buffered
// to ID over valid/ready, with redirect flush and stale-response discard.
module prefetch_buffer
  import prefetch_buffer_pkg::*;
#(
  parameter int unsigned DEPTH      = 4,
  parameter logic [31:0] RESET_ADDR = 32'h00000000,
  parameter logic [2:0]  ARPROT     = 3'b110
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        jump_taken,
  input  logic [31:0] jump_addr,
  output logic [31:0] imem_axi_araddr,
  output logic [2:0]  imem_axi_arprot,
  output logic        imem_axi_arvalid,
  input  logic        imem_axi_arready,
  input  logic [31:0] imem_axi_rdata,
  input  logic [1:0]  imem_axi_rresp,
  input  logic        imem_axi_rvalid,
  output logic        imem_axi_rready,
  output logic        valid_out,
  input  logic        ready_in,
  output logic [31:0] PC_IF,
  output logic [31:0] IR_IF,
  output logic        exc_pend_IF,
  output logic [31:0] exc_cause_IF
);

  localparam int unsigned CW = $clog2(DEPTH+1);
  localparam int unsigned OW = CW + 1;

  logic          arvalid_q;
  logic [31:0]   araddr_q, fetch_pc, fetch_pc_next, mis_pc;
  logic [CW-1:0] discard, discard_next, outstanding, fifo_count;
  logic          stale, halted, mis_pend;
  logic          pcq_nempty;
  logic [31:0]   pcq_head;
  logic          ar_hs, r_hs, drop_r, push_r, push_mis, fifo_push, fifo_pop, issue_ok;
  logic [OW-1:0] occ_next;
  fetch_entry_t  push_entry, head_entry;

  assign imem_axi_rready  = !reset;
  assign imem_axi_arprot  = ARPROT;
  assign imem_axi_arvalid = arvalid_q;
  assign imem_axi_araddr  = araddr_q;

  assign ar_hs     = arvalid_q && imem_axi_arready;
  assign r_hs      = imem_axi_rvalid && imem_axi_rready && pcq_nempty;
  assign drop_r    = r_hs && (jump_taken || discard != '0);
  assign push_r    = r_hs && !drop_r;
  assign push_mis  = mis_pend && discard == '0 && !stale && !jump_taken;
  assign fifo_push = push_r || push_mis;
  assign fifo_pop  = valid_out && ready_in && !jump_taken;

  always_comb begin
    push_entry.pc        = pcq_head;
    push_entry.ir        = imem_axi_rdata;
    push_entry.exc_pend  = (imem_axi_rresp != AXI_RESP_OKAY);
    push_entry.exc_cause = (imem_axi_rresp != AXI_RESP_OKAY) ? EXC_INSTR_ACCESS_FAULT : '0;
    if (!push_r) begin
      push_entry.pc        = mis_pc;
      push_entry.ir        = '0;
      push_entry.exc_pend  = 1'b1;
      push_entry.exc_cause = EXC_INSTR_MISALIGNED;
    end
  end

  // Occupancy seen by next cycle: in-flight reads plus buffered entries.
  assign occ_next = OW'(outstanding) + OW'(fifo_count) + OW'(ar_hs) - OW'(fifo_pop) - OW'(drop_r);
  assign issue_ok = !halted && !jump_taken && !stale && (occ_next < OW'(DEPTH));

  always_comb begin
    fetch_pc_next = fetch_pc;
    if (jump_taken)         fetch_pc_next = jump_addr;
    else if (ar_hs && !stale) fetch_pc_next = fetch_pc + 32'd4;
  end

  always_comb begin
    discard_next = discard;
    if (jump_taken) begin
      discard_next = outstanding + CW'(ar_hs) - CW'(r_hs);
    end else begin
      discard_next = discard - CW'(r_hs && discard != '0) + CW'(stale && ar_hs);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      arvalid_q <= 1'b0;
      araddr_q  <= RESET_ADDR;
      fetch_pc  <= RESET_ADDR;
      discard   <= '0;
      stale     <= 1'b0;
      halted    <= 1'b0;
      mis_pend  <= 1'b0;
      mis_pc    <= '0;
    end else begin
      fetch_pc <= fetch_pc_next;
      discard  <= discard_next;
      // A presented AR stays untouched until accepted, even across a redirect.
      if (!(arvalid_q && !imem_axi_arready)) begin
        arvalid_q <= issue_ok;
        if (issue_ok) araddr_q <= fetch_pc_next;
      end
      if (jump_taken) begin
        stale    <= arvalid_q && !imem_axi_arready;
        halted   <= |jump_addr[1:0];
        mis_pend <= |jump_addr[1:0];
        mis_pc   <= jump_addr;
      end else begin
        if (stale && ar_hs) stale <= 1'b0;
        if (push_mis)       mis_pend <= 1'b0;
      end
    end
  end

  fifo_sync #(.WIDTH(32), .DEPTH(DEPTH)) pc_queue (
    .clk       (clk),
    .reset     (reset),
    .flush     (1'b0),
    .push      (ar_hs),
    .push_data (araddr_q),
    .pop       (r_hs),
    .head      (pcq_head),
    .not_empty (pcq_nempty),
    .count     (outstanding)
  );

  fifo_sync #(.WIDTH($bits(fetch_entry_t)), .DEPTH(DEPTH)) entry_fifo (
    .clk       (clk),
    .reset     (reset),
    .flush     (jump_taken),
    .push      (fifo_push),
    .push_data (push_entry),
    .pop       (fifo_pop),
    .head      (head_entry),
    .not_empty (valid_out),
    .count     (fifo_count)
  );

  assign PC_IF        = head_entry.pc;
  assign IR_IF        = head_entry.ir;
  assign exc_pend_IF  = head_entry.exc_pend;
  assign exc_cause_IF = head_entry.exc_cause;

endmodule

// File: tb/tb_prefetch_buffer.sv
// Directed bench for prefetch_buffer with an in-order AXI4-Lite read responder.
module tb_prefetch_buffer;

  logic        clk = 1'b0;
  logic        reset, jump_taken, ready_in;
  logic [31:0] jump_addr;
  logic [31:0] araddr, rdata;
  logic [2:0]  arprot;
  logic        arvalid, arready, rvalid, rready;
  logic [1:0]  rresp;
  logic        valid_out, exc_pend;
  logic [31:0] pc_if, ir_if, exc_cause;

  always #5 clk = ~clk;

  prefetch_buffer #(.DEPTH(4), .RESET_ADDR(32'h0), .ARPROT(3'b110)) dut (
    .clk              (clk),
    .reset            (reset),
    .jump_taken       (jump_taken),
    .jump_addr        (jump_addr),
    .imem_axi_araddr  (araddr),
    .imem_axi_arprot  (arprot),
    .imem_axi_arvalid (arvalid),
    .imem_axi_arready (arready),
    .imem_axi_rdata   (rdata),
    .imem_axi_rresp   (rresp),
    .imem_axi_rvalid  (rvalid),
    .imem_axi_rready  (rready),
    .valid_out        (valid_out),
    .ready_in         (ready_in),
    .PC_IF            (pc_if),
    .IR_IF            (ir_if),
    .exc_pend_IF      (exc_pend),
    .exc_cause_IF     (exc_cause)
  );

  typedef struct {
    logic        ready_in;
    logic        arready;
    logic        rsp_en;
    logic        exp_arvalid;
    logic [31:0] exp_araddr;
    logic        exp_valid;
    logic [31:0] exp_pc;
  } vec_t;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] ir;
    logic        exc;
    logic [31:0] cause;
  } ent_t;

  vec_t        vecs [13];
  ent_t        pop_log [$];
  logic [31:0] ar_log [$];
  logic [31:0] rq [$];
  logic        rsp_en;
  logic [31:0] err_at;
  int unsigned n_checks = 0;
  int unsigned n_pass   = 0;

  function automatic logic [31:0] instr(input logic [31:0] a);
    return {a[15:0], 16'h0013};
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h, expected %h", nm, act, exp);
  endtask

  task automatic drive_r();
    if (rsp_en && rq.size() != 0) begin
      rvalid = 1'b1;
      rdata  = instr(rq[0]);
      rresp  = (rq[0] == err_at) ? 2'b10 : 2'b00;
    end else begin
      rvalid = 1'b0;
      rdata  = '0;
      rresp  = 2'b00;
    end
  endtask

  // One clock: record handshakes seen before the edge, then advance the responder.
  task automatic tick();
    logic        ar_hs, r_hs;
    logic [31:0] a;
    ent_t        e;
    drive_r();
    ar_hs = arvalid && arready;
    r_hs  = rvalid && rready;
    a     = araddr;
    if (valid_out && ready_in) begin
      e.pc = pc_if; e.ir = ir_if; e.exc = exc_pend; e.cause = exc_cause;
      pop_log.push_back(e);
    end
    if (ar_hs) ar_log.push_back(a);
    @(posedge clk);
    #1;
    if (r_hs) void'(rq.pop_front());
    if (ar_hs) rq.push_back(a);
    drive_r();
  endtask

  task automatic do_reset();
    reset      = 1'b1;
    jump_taken = 1'b0;
    jump_addr  = '0;
    rsp_en     = 1'b0;
    err_at     = 32'hFFFF_FFFF;
    rq.delete();
    drive_r();
    repeat (2) @(posedge clk);
    #1;
    chk("rst arvalid",   32'(arvalid),   32'd0);
    chk("rst valid_out", 32'(valid_out), 32'd0);
    chk("rst PC_IF",     pc_if,          32'd0);
    chk("rst IR_IF",     ir_if,          32'd0);
    chk("rst exc_pend",  32'(exc_pend),  32'd0);
    chk("rst exc_cause", exc_cause,      32'd0);
    chk("rst rready",    32'(rready),    32'd0);
    reset = 1'b0;
    ar_log.delete();
    pop_log.delete();
  endtask

  initial begin
    vecs[0]  = '{1'b1, 1'b1, 1'b1, 1'b1, 32'd0,  1'b0, 32'd0};
    vecs[1]  = '{1'b1, 1'b1, 1'b1, 1'b1, 32'd4,  1'b0, 32'd0};
    vecs[2]  = '{1'b1, 1'b1, 1'b1, 1'b1, 32'd8,  1'b1, 32'd0};
    vecs[3]  = '{1'b1, 1'b1, 1'b1, 1'b1, 32'd12, 1'b1, 32'd4};
    vecs[4]  = '{1'b1, 1'b1, 1'b1, 1'b1, 32'd16, 1'b1, 32'd8};
    vecs[5]  = '{1'b1, 1'b1, 1'b1, 1'b1, 32'd20, 1'b1, 32'd12};
    vecs[6]  = '{1'b1, 1'b1, 1'b1, 1'b1, 32'd24, 1'b1, 32'd16};
    vecs[7]  = '{1'b0, 1'b1, 1'b1, 1'b1, 32'd28, 1'b1, 32'd16};
    vecs[8]  = '{1'b0, 1'b1, 1'b1, 1'b0, 32'd0,  1'b1, 32'd16};
    vecs[9]  = '{1'b0, 1'b1, 1'b1, 1'b0, 32'd0,  1'b1, 32'd16};
    vecs[10] = '{1'b1, 1'b1, 1'b1, 1'b1, 32'd32, 1'b1, 32'd20};
    vecs[11] = '{1'b1, 1'b1, 1'b1, 1'b1, 32'd36, 1'b1, 32'd24};
    vecs[12] = '{1'b1, 1'b1, 1'b1, 1'b1, 32'd40, 1'b1, 32'd28};

    ready_in = 1'b0;
    arready  = 1'b0;
    do_reset();
    chk("arprot", 32'(arprot), 32'd6);

    // Streaming, then a short ID stall that fills the buffer.
    for (int i = 0; i < 13; i++) begin
      ready_in = vecs[i].ready_in;
      arready  = vecs[i].arready;
      rsp_en   = vecs[i].rsp_en;
      tick();
      chk($sformatf("vec%0d arvalid", i), 32'(arvalid), 32'(vecs[i].exp_arvalid));
      if (vecs[i].exp_arvalid) chk($sformatf("vec%0d araddr", i), araddr, vecs[i].exp_araddr);
      chk($sformatf("vec%0d valid_out", i), 32'(valid_out), 32'(vecs[i].exp_valid));
      if (vecs[i].exp_valid) begin
        chk($sformatf("vec%0d PC_IF", i), pc_if, vecs[i].exp_pc);
        chk($sformatf("vec%0d IR_IF", i), ir_if, instr(vecs[i].exp_pc));
      end
    end

    // Reset mid-stream; then backpressure limits issue to DEPTH reads.
    do_reset();
    ready_in = 1'b0; arready = 1'b1; rsp_en = 1'b1;
    repeat (12) tick();
    chk("bp ar count",   32'(ar_log.size()), 32'd4);
    chk("bp first ar",   ar_log[0],          32'd0);
    chk("bp arvalid",    32'(arvalid),       32'd0);
    chk("bp head pc",    pc_if,              32'd0);
    ready_in = 1'b1;
    tick();
    ready_in = 1'b0;
    ar_log.delete();
    repeat (8) tick();
    chk("bp refill count", 32'(ar_log.size()), 32'd1);
    chk("bp refill addr",  ar_log[0],          32'd16);
    chk("bp head after pop", pc_if,            32'd4);

    // Redirect with three reads outstanding.
    do_reset();
    ready_in = 1'b1; arready = 1'b1; rsp_en = 1'b0;
    repeat (3) tick();
    jump_taken = 1'b1; jump_addr = 32'h100;
    tick();
    jump_taken = 1'b0;
    chk("j3 arvalid after jump", 32'(arvalid), 32'd0);
    rsp_en = 1'b1;
    repeat (12) tick();
    chk("j3 ar before jump", 32'(ar_log.size() > 3), 32'd1);
    chk("j3 ar after jump",  ar_log[3],  32'h100);
    chk("j3 first pop pc",   pop_log[0].pc, 32'h100);
    chk("j3 first pop ir",   pop_log[0].ir, instr(32'h100));
    chk("j3 second pop pc",  pop_log[1].pc, 32'h104);

    // Redirect while an AR is presented but not accepted.
    do_reset();
    ready_in = 1'b1; arready = 1'b0; rsp_en = 1'b1;
    repeat (2) tick();
    jump_taken = 1'b1; jump_addr = 32'h200;
    tick();
    jump_taken = 1'b0;
    chk("stale arvalid held", 32'(arvalid), 32'd1);
    chk("stale araddr held",  araddr,       32'd0);
    tick();
    chk("stale araddr held2", araddr,       32'd0);
    arready = 1'b1;
    repeat (10) tick();
    chk("stale ar0",      ar_log[0],     32'd0);
    chk("stale ar1",      ar_log[1],     32'h200);
    chk("stale first pop", pop_log[0].pc, 32'h200);

    // Access fault on the read at 0x8; fetch carries on.
    do_reset();
    err_at = 32'h8;
    ready_in = 1'b1; arready = 1'b1; rsp_en = 1'b1;
    repeat (10) tick();
    chk("fault pc",         pop_log[2].pc,    32'h8);
    chk("fault exc_pend",   32'(pop_log[2].exc), 32'd1);
    chk("fault exc_cause",  pop_log[2].cause, 32'd1);
    chk("fault ir",         pop_log[2].ir,    instr(32'h8));
    chk("ok exc_pend",      32'(pop_log[1].exc), 32'd0);
    chk("after fault pc",   pop_log[3].pc,    32'hC);
    chk("after fault exc",  32'(pop_log[3].exc), 32'd0);

    // Misaligned redirect: one exception entry, then fetch halts.
    err_at = 32'hFFFF_FFFF;
    jump_taken = 1'b1; jump_addr = 32'h102;
    tick();
    jump_taken = 1'b0;
    ar_log.delete();
    pop_log.delete();
    repeat (15) tick();
    chk("mis pop count", 32'(pop_log.size()), 32'd1);
    chk("mis pc",        pop_log[0].pc,       32'h102);
    chk("mis ir",        pop_log[0].ir,       32'd0);
    chk("mis exc_pend",  32'(pop_log[0].exc), 32'd1);
    chk("mis exc_cause", pop_log[0].cause,    32'd0);
    chk("mis no ar",     32'(ar_log.size()),  32'd0);
    chk("mis arvalid",   32'(arvalid),        32'd0);
    jump_taken = 1'b1; jump_addr = 32'h300;
    tick();
    jump_taken = 1'b0;
    ar_log.delete();
    pop_log.delete();
    repeat (6) tick();
    chk("resume ar",  ar_log[0],     32'h300);
    chk("resume pop", pop_log[0].pc, 32'h300);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
